sorted_ram_writer: RTL and testbench

Writer side of the sorted-array binary-search lab: accepts 8-bit values one at a time and inserts each into a 32-entry on-chip array, keeping the array in ascending order so the binary-search block can read it directly. Insertion is a linear scan for the insert position followed by a one-entry-per-cycle shift. A read port gives the searcher access to the array, and two seven-segment outputs show where the last value landed.

---
 rtl/sorted_pkg.sv | 25 ++
 rtl/hex_to_7seg.sv | 38 +++
 rtl/sorted_ram.sv | 45 ++++
 rtl/sorted_ram_writer.sv | 189 ++++++++++++++++++
 tb/tb_sorted_ram_writer.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/sorted_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sorted_pkg
//  Purpose  : Shared sizing constants and state encoding for the sorted-array
//             writer and the binary-search reader.
//  Contents : DEPTH, WIDTH, AW (address width), CW (count width), state_t.
//  Revision : 1.0  initial release
// ============================================================================
package sorted_pkg;

  localparam int DEPTH = 32;
  localparam int WIDTH = 8;
  localparam int AW    = $clog2(DEPTH);
  // Count must represent 0..DEPTH inclusive, hence one extra bit.
  localparam int CW    = AW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/hex_to_7seg.sv
`default_nettype none
// ============================================================================
//  Module   : hex_to_7seg
//  Purpose  : Hexadecimal digit to active-low seven-segment pattern.
//  Ports    : hex_i [3:0]  digit to show
//             seg_o [6:0]  segments {g,f,e,d,c,b,a}, 0 = lit
//  Revision : 1.0  initial release
// ============================================================================
module hex_to_7seg (
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = 7'b1111111;
    case (hex_i)
      4'h0: seg_o = 7'b1000000;
      4'h1: seg_o = 7'b1111001;
      4'h2: seg_o = 7'b0100100;
      4'h3: seg_o = 7'b0110000;
      4'h4: seg_o = 7'b0011001;
      4'h5: seg_o = 7'b0010010;
      4'h6: seg_o = 7'b0000010;
      4'h7: seg_o = 7'b1111000;
      4'h8: seg_o = 7'b0000000;
      4'h9: seg_o = 7'b0010000;
      4'hA: seg_o = 7'b0001000;
      4'hB: seg_o = 7'b0000011;
      4'hC: seg_o = 7'b1000110;
      4'hD: seg_o = 7'b0100001;
      4'hE: seg_o = 7'b0000110;
      4'hF: seg_o = 7'b0001110;
      default: seg_o = 7'b1111111;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/sorted_ram.sv
`default_nettype none
// ============================================================================
//  Module   : sorted_ram
//  Purpose  : DEPTH x WIDTH register array with one synchronous write port,
//             two asynchronous read ports and a synchronous clear.
//  Ports    : clk, reset            clock / sync active-high clear
//             we_i, waddr_i, wdata_i write port
//             raddr_a_i, rdata_a_o  datapath read port (scan / shift)
//             raddr_b_i, rdata_b_o  searcher read port
//  Revision : 1.0  initial release
// ============================================================================
module sorted_ram
  import sorted_pkg::*;
#(
  parameter int DEPTH = sorted_pkg::DEPTH,
  parameter int WIDTH = sorted_pkg::WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_a_i,
  output logic [WIDTH-1:0]         rdata_a_o,
  input  logic [$clog2(DEPTH)-1:0] raddr_b_i,
  output logic [WIDTH-1:0]         rdata_b_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];

endmodule
`default_nettype wire

// File: rtl/sorted_ram_writer.sv
`default_nettype none
// ============================================================================
//  Module   : sorted_ram_writer
//  Purpose  : Inserts values one at a time into an ascending-ordered array
//             (linear scan for position, then one-entry-per-cycle shift up).
//  Ports    : clk, reset     clock / sync active-high reset
//             start, A       insert request (level) and value
//             rd_addr/rd_data searcher read port (valid while busy=0)
//             count          valid entries 0..DEPTH
//             busy, done     SCAN|SHIFT, DONE
//             full           last request rejected (array full)
//             hx0, hx1       active-low hex of insert position (low/high)
//  Revision : 1.0  initial release
// ============================================================================
module sorted_ram_writer
  import sorted_pkg::*;
#(
  parameter int DEPTH = sorted_pkg::DEPTH,
  parameter int WIDTH = sorted_pkg::WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [WIDTH-1:0]         A,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     busy,
  output logic                     done,
  output logic                     full,
  output logic [6:0]               hx0,
  output logic [6:0]               hx1
);

  localparam int LAW = $clog2(DEPTH);
  localparam int LCW = LAW + 1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] val_q,   val_d;
  logic [LCW-1:0]   idx_q,   idx_d;
  logic [LCW-1:0]   j_q,     j_d;
  logic [LAW-1:0]   pos_q,   pos_d;
  logic [LCW-1:0]   count_q, count_d;
  logic             full_q,  full_d;

  logic             mem_we;
  logic [LAW-1:0]   mem_waddr;
  logic [WIDTH-1:0] mem_wdata;
  logic [LAW-1:0]   mem_raddr;
  logic [WIDTH-1:0] mem_rdata;
  logic [LCW-1:0]   j_minus1;

  assign j_minus1 = j_q - LCW'(1);

  sorted_ram #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_ram (
    .clk       (clk),
    .reset     (reset),
    .we_i      (mem_we),
    .waddr_i   (mem_waddr),
    .wdata_i   (mem_wdata),
    .raddr_a_i (mem_raddr),
    .rdata_a_o (mem_rdata),
    .raddr_b_i (rd_addr),
    .rdata_b_o (rd_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      val_q   <= '0;
      idx_q   <= '0;
      j_q     <= '0;
      pos_q   <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      idx_q   <= idx_d;
      j_q     <= j_d;
      pos_q   <= pos_d;
      count_q <= count_d;
      full_q  <= full_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    val_d     = val_q;
    idx_d     = idx_q;
    j_d       = j_q;
    pos_d     = pos_q;
    count_d   = count_q;
    full_d    = full_q;
    mem_we    = 1'b0;
    mem_waddr = j_q[LAW-1:0];
    mem_wdata = mem_rdata;
    mem_raddr = idx_q[LAW-1:0];

    case (state_q)
      IDLE: begin
        if (start) begin
          if (count_q < LCW'(DEPTH)) begin
            val_d   = A;
            idx_d   = '0;
            full_d  = 1'b0;
            state_d = SCAN;
          end else begin
            full_d  = 1'b1;
            state_d = DONE;
          end
        end
      end

      SCAN: begin
        mem_raddr = idx_q[LAW-1:0];
        // Strict '>' keeps a duplicate after the existing equal entries.
        if ((idx_q == count_q) || (mem_rdata > val_q)) begin
          pos_d   = idx_q[LAW-1:0];
          j_d     = count_q;
          state_d = SHIFT;
        end else begin
          idx_d = idx_q + LCW'(1);
        end
      end

      SHIFT: begin
        // j never exceeds DEPTH-1 here since count < DEPTH was checked.
        mem_raddr = j_minus1[LAW-1:0];
        if (j_q > {1'b0, pos_q}) begin
          mem_we    = 1'b1;
          mem_waddr = j_q[LAW-1:0];
          mem_wdata = mem_rdata;
          j_d       = j_minus1;
        end else begin
          mem_we    = 1'b1;
          mem_waddr = pos_q;
          mem_wdata = val_q;
          count_d   = count_q + LCW'(1);
          state_d   = DONE;
        end
      end

      DONE: begin
        if (!start) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign count = count_q;
  assign busy  = (state_q == SCAN) || (state_q == SHIFT);
  assign done  = (state_q == DONE);
  assign full  = full_q;

  // Display: low nibble of pos, and the bit(s) above it collapsed to 0/1.
  logic       show_pos;
  logic [3:0] hex_lo;
  logic [3:0] hex_hi;
  logic [6:0] seg_lo;
  logic [6:0] seg_hi;

  assign show_pos = done && !full_q;
  assign hex_lo   = pos_q[3:0];
  assign hex_hi   = {3'b000, |(pos_q >> 4)};

  hex_to_7seg u_hex0 (
    .hex_i (hex_lo),
    .seg_o (seg_lo)
  );

  hex_to_7seg u_hex1 (
    .hex_i (hex_hi),
    .seg_o (seg_hi)
  );

  assign hx0 = show_pos ? seg_lo : 7'b1111111;
  assign hx1 = show_pos ? seg_hi : 7'b1111111;

endmodule
`default_nettype wire

// File: tb/tb_sorted_ram_writer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sorted_ram_writer
//  Purpose  : Directed self-checking bench for sorted_ram_writer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sorted_ram_writer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] A;
  logic [4:0] rd_addr;
  logic [7:0] rd_data;
  logic [5:0] count;
  logic       busy;
  logic       done;
  logic       full;
  logic [6:0] hx0;
  logic [6:0] hx1;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] model [32];
  int         model_n;

  localparam logic [6:0] BLANK = 7'b1111111;

  always #5 clk = ~clk;

  sorted_ram_writer dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .A       (A),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .count   (count),
    .busy    (busy),
    .done    (done),
    .full    (full),
    .hx0     (hx0),
    .hx1     (hx1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'b1000000;  4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;  4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;  4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;  4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;  4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;  4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;  4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;  default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_n = 0;
    for (int i = 0; i < 32; i++) model[i] = 8'h00;
  endtask

  // Compare all 32 entries against the model (entries past model_n are 0).
  task automatic check_array(input string tag);
    for (int i = 0; i < 32; i++) begin
      rd_addr = 5'(i);
      #1;
      check(tag, {24'h0, rd_data}, {24'h0, model[i]});
    end
  endtask

  // Accepted insert: exp_pos hand-computed; exp_n is count before insert.
  task automatic do_insert(input logic [7:0] v, input int exp_pos, input int exp_n, input int hold);
    int n;
    logic got;
    logic [7:0] pv;
    @(negedge clk);
    A = v;
    start = 1'b1;
    n = 0;
    got = 1'b0;
    while (!got && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) A = ~v;
      if (done) got = 1'b1;
    end
    check("done_seen", {31'h0, got}, 32'h1);
    check("latency", n, exp_n + 3);
    pv = 8'(exp_pos);
    check("count", {26'h0, count}, exp_n + 1);
    check("full_low", {31'h0, full}, 32'h0);
    check("hx0", {25'h0, hx0}, {25'h0, seg(pv[3:0])});
    check("hx1", {25'h0, hx1}, {25'h0, seg({3'b000, pv[4]})});
    for (int i = model_n; i > exp_pos; i--) model[i] = model[i-1];
    model[exp_pos] = v;
    model_n++;
    repeat (hold) begin
      @(posedge clk);
      #1;
      check("hold_done", {31'h0, done}, 32'h1);
      check("hold_count", {26'h0, count}, exp_n + 1);
    end
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    check("idle_done", {31'h0, done}, 32'h0);
    check("idle_busy", {31'h0, busy}, 32'h0);
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    A       = 8'h00;
    rd_addr = 5'd0;
    model_n = 0;
    do_reset();
    #1;
    check("rst_count", {26'h0, count}, 32'h0);
    check("rst_busy",  {31'h0, busy},  32'h0);
    check("rst_done",  {31'h0, done},  32'h0);
    check("rst_full",  {31'h0, full},  32'h0);
    check("rst_hx0",   {25'h0, hx0},   {25'h0, BLANK});
    check("rst_hx1",   {25'h0, hx1},   {25'h0, BLANK});
    check_array("rst_mem");

    // First insert into empty array, then build 02,05,07,09.
    do_insert(8'h05, 0, 0, 0);
    check_array("arr_05");
    do_insert(8'h09, 1, 1, 0);
    do_insert(8'h02, 0, 2, 0);
    do_insert(8'h07, 2, 3, 0);
    check_array("arr_4");
    rd_addr = 5'd0; #1; check("arr0", {24'h0, rd_data}, 32'h02);
    rd_addr = 5'd3; #1; check("arr3", {24'h0, rd_data}, 32'h09);

    // Duplicate lands after the existing equal entry.
    do_insert(8'h05, 2, 4, 0);
    check_array("arr_dup");

    // Fill the remaining 27 slots with values that append.
    for (int i = 0; i < 27; i++) do_insert(8'(8'h10 + i), 5 + i, 5 + i, 0);
    check("filled", {26'h0, count}, 32'd32);
    check_array("arr_full");

    // Rejected insert: done and full after E0, nothing written.
    begin
      int n;
      @(negedge clk);
      A = 8'h00;
      start = 1'b1;
      n = 0;
      while (!done && n < 50) begin
        @(posedge clk);
        #1;
        n++;
      end
      check("rej_latency", n, 1);
      check("rej_full", {31'h0, full}, 32'h1);
      check("rej_count", {26'h0, count}, 32'd32);
      check("rej_hx0", {25'h0, hx0}, {25'h0, BLANK});
      check("rej_hx1", {25'h0, hx1}, {25'h0, BLANK});
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      #1;
      check("rej_idle", {31'h0, done}, 32'h0);
      check_array("arr_rej");
    end

    // Start held through DONE: exactly one insert.
    do_reset();
    do_insert(8'h33, 0, 0, 10);
    do_insert(8'h11, 0, 1, 0);
    check_array("arr_hold");

    // Reset in the middle of the shift of a 10-entry array.
    do_reset();
    for (int i = 0; i < 10; i++) do_insert(8'(8'h20 + i), i, i, 0);
    check("pre_count", {26'h0, count}, 32'd10);
    @(negedge clk);
    A = 8'h01;
    start = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("mid_busy", {31'h0, busy}, 32'h1);
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1;
    check("mr_count", {26'h0, count}, 32'h0);
    check("mr_busy",  {31'h0, busy},  32'h0);
    check("mr_done",  {31'h0, done},  32'h0);
    for (int i = 0; i < 32; i++) model[i] = 8'h00;
    model_n = 0;
    check_array("mr_mem");
    @(negedge clk);
    reset = 1'b0;
    do_insert(8'h44, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
